// File: rtl/bus_sync_6502.sv
// 6502 bus front-end: synchronises the asynchronous bus into clk, filters phi2
// glitches, and turns each selected bus cycle into a read strobe or a FIFO write.
module bus_sync_6502 #(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_HIGH    = 3,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_ext1,
    input  logic       cs,
    input  logic [3:0] rs,
    input  logic       wren,
    input  logic [7:0] data_in,
    output logic       rd_stb,
    output logic [3:0] rd_addr,
    output logic       wr_valid,
    output logic [3:0] wr_addr,
    output logic [7:0] wr_data,
    input  logic       wr_ready,
    output logic       overflow,
    input  logic       ovf_clr
);
    localparam int BW  = 15;
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam int FCW = $clog2(MIN_HIGH + 1);

    typedef enum logic [2:0] {WAIT_LOW, LOW, FILTER, RD, WR, SKIP} state_t;

    // All bus bits share one chain so they stay aligned with phi2.
    logic [BW-1:0] bus_raw;
    logic [BW-1:0] sync_q [SYNC_STAGES];
    logic [BW-1:0] bus_s;

    assign bus_raw = {clk_ext1, cs, wren, rs, data_in};

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) sync_q[gi] <= '0;
                    else        sync_q[gi] <= bus_raw;
                end
            end else begin : g_rest
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) sync_q[gi] <= '0;
                    else        sync_q[gi] <= sync_q[gi-1];
                end
            end
        end
    endgenerate

    assign bus_s = sync_q[SYNC_STAGES-1];

    logic       phi2_s, cs_s, wren_s;
    logic [3:0] rs_s;
    logic [7:0] data_s;
    assign phi2_s = bus_s[14];
    assign cs_s   = bus_s[13];
    assign wren_s = bus_s[12];
    assign rs_s   = bus_s[11:8];
    assign data_s = bus_s[7:0];

    // The chain holds reset zeros for a while; a real low phase is only trusted once it has refilled.
    logic [SYNC_STAGES-1:0] fill_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fill_q <= '0;
        else        fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
    end

    state_t     state_q, state_d;
    logic [FCW-1:0] cnt_q, cnt_d;
    logic [3:0] rs_lat_q, rs_lat_d;
    logic [7:0] cap_q, cap_d;
    logic       rd_stb_q, rd_stb_d;
    logic [3:0] rd_addr_q, rd_addr_d;
    logic       push;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rs_lat_d  = rs_lat_q;
        cap_d     = cap_q;
        rd_stb_d  = 1'b0;
        rd_addr_d = rd_addr_q;
        push      = 1'b0;
        case (state_q)
            WAIT_LOW: if (fill_q[SYNC_STAGES-1] && !phi2_s) state_d = LOW;
            LOW: begin
                if (phi2_s) begin
                    state_d = FILTER;
                    cnt_d   = FCW'(1);
                end
            end
            FILTER: begin
                if (!phi2_s) begin
                    state_d = LOW;
                end else if (cnt_q == FCW'(MIN_HIGH)) begin
                    if (cs_s) begin
                        state_d = SKIP;
                    end else begin
                        rs_lat_d = rs_s;
                        cap_d    = data_s;
                        if (wren_s) begin
                            state_d   = RD;
                            rd_stb_d  = 1'b1;
                            rd_addr_d = rs_s;
                        end else begin
                            state_d = WR;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + FCW'(1);
                end
            end
            RD:   if (!phi2_s) state_d = LOW;
            WR: begin
                // Data is taken from the cycle before the fall, never from the falling cycle.
                if (phi2_s) begin
                    cap_d = data_s;
                end else begin
                    push    = 1'b1;
                    state_d = LOW;
                end
            end
            SKIP: if (!phi2_s) state_d = LOW;
            default: state_d = WAIT_LOW;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= WAIT_LOW;
            cnt_q     <= '0;
            rs_lat_q  <= '0;
            cap_q     <= '0;
            rd_stb_q  <= 1'b0;
            rd_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rs_lat_q  <= rs_lat_d;
            cap_q     <= cap_d;
            rd_stb_q  <= rd_stb_d;
            rd_addr_q <= rd_addr_d;
        end
    end

    assign rd_stb  = rd_stb_q;
    assign rd_addr = rd_addr_q;

    // Write FIFO: entries are {rs, data}.
    logic [11:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] head_q, tail_q;
    logic [CW-1:0] count_q;
    logic [11:0]   hold_q;
    logic          overflow_q;
    logic          full, pop, push_ok, drop;

    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign pop     = (count_q != '0) && wr_ready;
    assign push_ok = push && (!full || pop);
    assign drop    = push && full && !pop;

    always_ff @(posedge clk) begin
        if (push_ok) mem[tail_q] <= {rs_lat_q, cap_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            hold_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (pop) begin
                head_q <= head_q + PW'(1);
                hold_q <= mem[head_q];
            end
            if (push_ok) tail_q <= tail_q + PW'(1);
            if (push_ok && !pop)      count_q <= count_q + CW'(1);
            else if (pop && !push_ok) count_q <= count_q - CW'(1);
            if (drop)         overflow_q <= 1'b1;
            else if (ovf_clr) overflow_q <= 1'b0;
        end
    end

    logic [11:0] head_entry;
    assign head_entry = (count_q != '0) ? mem[head_q] : hold_q;
    assign wr_valid   = (count_q != '0);
    assign wr_addr    = head_entry[11:8];
    assign wr_data    = head_entry[7:0];
    assign overflow   = overflow_q;

endmodule
